// File: rtl/commit_trace_serializer_if.sv
// Retire-side and checker-side signal bundle for the commit trace serializer.
// The master modport is the harness (drives retire events, consumes the stream);
// the slave modport is the serializer itself.
interface commit_trace_serializer_if #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [COMMITS-1:0]    in_valid;
  logic [64*COMMITS-1:0] in_pc;
  logic [32*COMMITS-1:0] in_insn;
  logic [COMMITS-1:0]    in_wen;
  logic [5*COMMITS-1:0]  in_waddr;
  logic [64*COMMITS-1:0] in_wdata;
  logic                  trap_valid;
  logic [63:0]           trap_cause;
  logic                  in_ready;

  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            out_kind;
  logic [63:0]           out_pc;
  logic [31:0]           out_insn;
  logic [4:0]            out_waddr;
  logic [63:0]           out_wdata;
  logic [15:0]           out_seq;
  logic                  overflow;
  logic [LW-1:0]         level;

  modport master (
    output in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
    output trap_valid, trap_cause, out_ready,
    input  in_ready, out_valid, out_kind, out_pc, out_insn,
    input  out_waddr, out_wdata, out_seq, overflow, level
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_wen, in_waddr, in_wdata,
    input  trap_valid, trap_cause, out_ready,
    output in_ready, out_valid, out_kind, out_pc, out_insn,
    output out_waddr, out_wdata, out_seq, overflow, level
  );
endinterface

// File: rtl/commit_trace_serializer.sv
// Packs up to COMMITS commits plus one trap per cycle into an in-order FIFO
// and drains it one event per cycle towards the co-simulation checker.
// Whole groups are accepted or dropped; occupancy alone decides full/empty.
module commit_trace_serializer #(
  parameter int COMMITS = 2,
  parameter int DEPTH   = 8
) (
  input logic clock,
  input logic reset,
  commit_trace_serializer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [15:0]   seq_reg;
  logic          overflow_reg;

  // Head slot is read combinationally, so storage is plain register arrays.
  logic [1:0]  kind_mem  [DEPTH];
  logic [63:0] pc_mem    [DEPTH];
  logic [31:0] insn_mem  [DEPTH];
  logic [4:0]  waddr_mem [DEPTH];
  logic [63:0] wdata_mem [DEPTH];

  logic [LW-1:0] lane_off [COMMITS];
  logic [LW-1:0] commit_cnt;
  logic [LW-1:0] group_n;
  logic [LW-1:0] free_slots;
  logic          ready;
  logic          enq;
  logic          deq;

  // Slot offset of each valid lane within the group, and the group size.
  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < COMMITS; i++) begin
      lane_off[i] = commit_cnt;
      commit_cnt  = commit_cnt + LW'(bus.in_valid[i]);
    end
    group_n    = commit_cnt + LW'(bus.trap_valid);
    free_slots = LW'(DEPTH) - level_reg;
    ready      = (free_slots >= LW'(COMMITS + 1));
    enq        = ready && (group_n != '0);
    deq        = (level_reg != '0) && bus.out_ready;
  end

  // Write an accepted group into consecutive slots, trap last.
  always_ff @(posedge clock) begin
    if (reset && enq) begin
      for (int i = 0; i < COMMITS; i++) begin
        if (bus.in_valid[i]) begin
          kind_mem [wr_ptr_reg + PW'(lane_off[i])] <= bus.in_wen[i] ? 2'd1 : 2'd0;
          pc_mem   [wr_ptr_reg + PW'(lane_off[i])] <= bus.in_pc[64*i +: 64];
          insn_mem [wr_ptr_reg + PW'(lane_off[i])] <= bus.in_insn[32*i +: 32];
          waddr_mem[wr_ptr_reg + PW'(lane_off[i])] <= bus.in_wen[i] ? bus.in_waddr[5*i +: 5] : 5'd0;
          wdata_mem[wr_ptr_reg + PW'(lane_off[i])] <= bus.in_wen[i] ? bus.in_wdata[64*i +: 64] : 64'd0;
        end
      end
      if (bus.trap_valid) begin
        kind_mem [wr_ptr_reg + PW'(commit_cnt)] <= 2'd2;
        pc_mem   [wr_ptr_reg + PW'(commit_cnt)] <= 64'd0;
        insn_mem [wr_ptr_reg + PW'(commit_cnt)] <= 32'd0;
        waddr_mem[wr_ptr_reg + PW'(commit_cnt)] <= 5'd0;
        wdata_mem[wr_ptr_reg + PW'(commit_cnt)] <= bus.trap_cause;
      end
    end
  end

  // Pointer, occupancy, sequence and sticky overflow bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(group_n);
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
        seq_reg    <= seq_reg + 16'd1;
      end
      level_reg <= level_reg + (enq ? group_n : LW'(0)) - LW'(deq);
      if ((group_n != '0) && !ready) overflow_reg <= 1'b1;
    end
  end

  // Head fields read as zero whenever the FIFO is empty.
  always_comb begin
    bus.in_ready  = ready;
    bus.out_valid = (level_reg != '0);
    bus.out_seq   = seq_reg;
    bus.overflow  = overflow_reg;
    bus.level     = level_reg;
    bus.out_kind  = 2'd0;
    bus.out_pc    = 64'd0;
    bus.out_insn  = 32'd0;
    bus.out_waddr = 5'd0;
    bus.out_wdata = 64'd0;
    if (level_reg != '0) begin
      bus.out_kind  = kind_mem[rd_ptr_reg];
      bus.out_pc    = pc_mem[rd_ptr_reg];
      bus.out_insn  = insn_mem[rd_ptr_reg];
      bus.out_waddr = waddr_mem[rd_ptr_reg];
      bus.out_wdata = wdata_mem[rd_ptr_reg];
    end
  end
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench for commit_trace_serializer with COMMITS=2, DEPTH=8.
module tb_commit_trace_serializer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   deq_cnt;
  int   cyc;

  always #5 clock = ~clock;

  commit_trace_serializer_if #(.COMMITS(2), .DEPTH(8)) bus ();

  commit_trace_serializer #(.COMMITS(2), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic [31:0] insn0, input logic [31:0] insn1, input logic [1:0] wen,
                       input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [63:0] wd0, input logic [63:0] wd1,
                       input logic trap, input logic [63:0] cause);
    bus.in_valid   = v;
    bus.in_pc      = {pc1, pc0};
    bus.in_insn    = {insn1, insn0};
    bus.in_wen     = wen;
    bus.in_waddr   = {wa1, wa0};
    bus.in_wdata   = {wd1, wd0};
    bus.trap_valid = trap;
    bus.trap_cause = cause;
  endtask

  task automatic idle();
    drive(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [63:0] exp_pc [6];
  logic [1:0]  exp_kind [6];

  initial begin
    idle();
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    // Reset then idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      chk("idle_level", 64'(bus.level), 0);
      chk("idle_out_valid", 64'(bus.out_valid), 0);
      chk("idle_in_ready", 64'(bus.in_ready), 1);
      chk("idle_seq", 64'(bus.out_seq), 0);
      chk("idle_overflow", 64'(bus.overflow), 0);
      tick();
    end
    $display("txn idle: level=%0d in_ready=%0b", bus.level, bus.in_ready);

    // Sparse lanes: only lane 1 valid.
    drive(2'b10, 64'h0, 64'h80000004, 32'h0, 32'h00a00093, 2'b10, 5'd0, 5'd1, 64'd0, 64'd10, 1'b0, 0);
    tick();
    idle();
    chk("sparse_valid", 64'(bus.out_valid), 1);
    chk("sparse_kind", 64'(bus.out_kind), 1);
    chk("sparse_pc", bus.out_pc, 64'h80000004);
    chk("sparse_insn", 64'(bus.out_insn), 64'h00a00093);
    chk("sparse_waddr", 64'(bus.out_waddr), 1);
    chk("sparse_wdata", bus.out_wdata, 10);
    chk("sparse_seq", 64'(bus.out_seq), 0);
    chk("sparse_level", 64'(bus.level), 1);
    $display("txn sparse: kind=%0d pc=%0h seq=%0d", bus.out_kind, bus.out_pc, bus.out_seq);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("sparse_empty", 64'(bus.out_valid), 0);
    chk("sparse_zero_pc", bus.out_pc, 0);
    chk("sparse_seq_after", 64'(bus.out_seq), 1);

    // Same-cycle ordering: lane0, lane1, then trap.
    do_reset();
    drive(2'b11, 64'h100, 64'h104, 32'h00000013, 32'h00208093, 2'b10, 5'd7, 5'd1,
          64'hdead, 64'h55, 1'b1, 64'h2);
    tick();
    idle();
    chk("order_level", 64'(bus.level), 3);
    bus.out_ready = 1'b1;
    chk("order0_kind", 64'(bus.out_kind), 0);
    chk("order0_pc", bus.out_pc, 64'h100);
    chk("order0_waddr", 64'(bus.out_waddr), 0);
    chk("order0_wdata", bus.out_wdata, 0);
    chk("order0_seq", 64'(bus.out_seq), 0);
    $display("txn order0: kind=%0d pc=%0h seq=%0d", bus.out_kind, bus.out_pc, bus.out_seq);
    tick();
    chk("order1_kind", 64'(bus.out_kind), 1);
    chk("order1_pc", bus.out_pc, 64'h104);
    chk("order1_waddr", 64'(bus.out_waddr), 1);
    chk("order1_wdata", bus.out_wdata, 64'h55);
    chk("order1_seq", 64'(bus.out_seq), 1);
    $display("txn order1: kind=%0d pc=%0h seq=%0d", bus.out_kind, bus.out_pc, bus.out_seq);
    tick();
    chk("order2_kind", 64'(bus.out_kind), 2);
    chk("order2_pc", bus.out_pc, 0);
    chk("order2_insn", 64'(bus.out_insn), 0);
    chk("order2_wdata", bus.out_wdata, 64'h2);
    chk("order2_seq", 64'(bus.out_seq), 2);
    $display("txn order2: kind=%0d cause=%0h seq=%0d", bus.out_kind, bus.out_wdata, bus.out_seq);
    tick();
    bus.out_ready = 1'b0;
    chk("order_drained", 64'(bus.out_valid), 0);

    // Backpressure: accepts at levels 0, 2, 4; fourth group dropped.
    for (int g = 0; g < 4; g++) begin
      chk("bp_level", 64'(bus.level), 64'(g < 3 ? 2 * g : 6));
      chk("bp_in_ready", 64'(bus.in_ready), (g < 3) ? 64'd1 : 64'd0);
      drive(2'b11, 64'h1000 + 64'(16 * g), 64'h1008 + 64'(16 * g), 32'h13, 32'h93, 2'b10,
            5'd0, 5'd2, 64'd0, 64'(g), 1'b0, 0);
      tick();
      $display("txn bp group %0d: level=%0d overflow=%0b", g, bus.level, bus.overflow);
    end
    idle();
    chk("bp_full_level", 64'(bus.level), 6);
    chk("bp_overflow", 64'(bus.overflow), 1);
    chk("bp_full_ready", 64'(bus.in_ready), 0);

    // One dequeue brings level to 5, then enqueue and dequeue together.
    bus.out_ready = 1'b1;
    tick();
    chk("sim_level5", 64'(bus.level), 5);
    chk("sim_ready5", 64'(bus.in_ready), 1);
    chk("sim_head", bus.out_pc, 64'h1008);
    drive(2'b11, 64'h2000, 64'h2008, 32'h13, 32'h93, 2'b10, 5'd0, 5'd3, 64'd0, 64'h77, 1'b0, 0);
    tick();
    idle();
    chk("sim_level6", 64'(bus.level), 6);
    $display("txn simul: level=%0d", bus.level);

    // Drain across the pointer wrap in original order.
    exp_pc   = '{64'h1010, 64'h1018, 64'h1020, 64'h1028, 64'h2000, 64'h2008};
    exp_kind = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    for (int k = 0; k < 6; k++) begin
      chk("drain_valid", 64'(bus.out_valid), 1);
      chk("drain_pc", bus.out_pc, exp_pc[k]);
      chk("drain_kind", 64'(bus.out_kind), 64'(exp_kind[k]));
      $display("txn drain %0d: kind=%0d pc=%0h seq=%0d", k, bus.out_kind, bus.out_pc, bus.out_seq);
      tick();
    end
    chk("drain_empty", 64'(bus.out_valid), 0);
    chk("drain_level", 64'(bus.level), 0);
    chk("overflow_sticky", 64'(bus.overflow), 1);
    bus.out_ready = 1'b0;

    // Sequence wrap: continuous traffic, 65537 dequeues.
    do_reset();
    chk("wrap_seq_start", 64'(bus.out_seq), 0);
    chk("wrap_overflow_cleared", 64'(bus.overflow), 0);
    drive(2'b11, 64'h3000, 64'h3004, 32'h13, 32'h93, 2'b10, 5'd0, 5'd4, 64'd0, 64'h9, 1'b1, 64'h8);
    bus.out_ready = 1'b1;
    deq_cnt = 0;
    cyc = 0;
    while (deq_cnt < 65537 && cyc < 70000) begin
      if (bus.out_valid) begin
        if (deq_cnt == 65535) chk("wrap_seq_ffff", 64'(bus.out_seq), 64'hFFFF);
        if (deq_cnt == 65536) chk("wrap_seq_0000", 64'(bus.out_seq), 64'h0);
        deq_cnt++;
      end
      tick();
      cyc++;
    end
    chk("wrap_done", 64'(deq_cnt), 65537);
    $display("txn wrap: dequeues=%0d cycles=%0d seq=%0h", deq_cnt, cyc, bus.out_seq);
    chk("wrap_busy", 64'(bus.out_valid), 1);

    // Reset mid-burst with inputs still presented.
    do_reset();
    chk("midrst_valid", 64'(bus.out_valid), 0);
    chk("midrst_level", 64'(bus.level), 0);
    chk("midrst_seq", 64'(bus.out_seq), 0);
    $display("txn midreset: level=%0d out_valid=%0b", bus.level, bus.out_valid);
    idle();
    bus.out_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/commit_trace_serializer.md
# commit_trace_serializer

Collects per-cycle retirement events from a multi-commit core, packing up to COMMITS instruction commits plus at most one trap per cycle into an in-order FIFO. It drains the FIFO one event per cycle over a valid/ready stream to the co-simulation checker, which consumes one commit or trap at a time. It is the producer end of the commit/trap checking path. It sits between the core's retire stage and the checker adapter in the testbench harness.

## Interface
- COMMITS, 2, commit lanes per cycle (1..4)
- DEPTH, 8, FIFO entries; power of two, ≥ COMMITS+1
- clock  in  1  clock, all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- in_valid  in  COMMITS  per-lane commit valid; lanes need not be contiguous
- in_pc  in  64*COMMITS  lane i at [64i+63:64i]
- in_insn  in  32*COMMITS  lane i instruction word
- in_wen  in  COMMITS  lane i writes a register
- in_waddr  in  5*COMMITS  lane i destination register
- in_wdata  in  64*COMMITS  lane i writeback data
- trap_valid  in  1  trap raised this cycle; ordered after all same-cycle commits
- trap_cause  in  64  trap cause
- in_ready  out  1  group accepted this cycle
- out_valid  out  1  head entry present
- out_ready  in  1  checker consumes head
- out_kind  out  2  0 commit without writeback, 1 commit with writeback, 2 trap
- out_pc  out  64  commit pc; 0 for trap
- out_insn  out  32  commit instruction; 0 for trap
- out_waddr  out  5  destination register; 0 unless kind 1
- out_wdata  out  64  writeback data (kind 1), trap cause (kind 2), else 0
- out_seq  out  16  sequence number of head entry
- overflow  out  1  sticky: events presented while in_ready low
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Enqueue group = set lanes of in_valid in ascending lane order, then trap if trap_valid; size n = popcount(in_valid) + trap_valid, 0..COMMITS+1.
- in_ready = (DEPTH − level) ≥ COMMITS+1, from registered occupancy only; it does not depend on the inputs or on out_ready in the same cycle.
- Group written when in_ready=1 and n>0: entry k goes to slot wr_ptr+k (mod DEPTH); wr_ptr += n.
- Kind encoding at enqueue: commit lane with in_wen=1 gives kind 1. Commit lane with in_wen=0 gives kind 0, with waddr/wdata stored as 0. Trap gives kind 2, with pc/insn/waddr stored as 0.
- Dequeue when out_valid && out_ready: rd_ptr += 1, out_seq += 1 (wraps 0xFFFF→0x0000).
- Simultaneous enqueue and dequeue: level_next = level + n − deq.
- Output fields are combinational reads of the head slot; they are stable while out_valid=1 and out_ready=0.
- If n>0 and in_ready=0, the whole group is dropped (no partial accept) and overflow is set. overflow clears only on reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are decided by level, not by pointer compare.

## Timing
- Reset (reset=0 at a rising edge): level=0, pointers=0, out_seq=0, overflow=0. Consequently out_valid=0 and in_ready=1 in the following cycle. FIFO contents are don't-care but outputs must read 0 while out_valid=0.
- Reset mid-stream discards all queued entries. Inputs are ignored during any cycle in which reset=0.
- Latency: an event enqueued at edge t appears at the head (if the FIFO was empty) with out_valid=1 in cycle t+1. There is no same-cycle bypass.
- Throughput: one dequeue per cycle sustained; up to COMMITS+1 enqueues per cycle.
- out_valid must not drop without a dequeue. The head changes only on a dequeue edge.

## Test plan
- Reset then idle: level=0, out_valid=0, in_ready=1, out_seq=0, overflow=0 for 10 cycles.
- Sparse lanes: in_valid=2'b10, lane1 pc=0x80000004, insn=0x00a00093, wen=1, waddr=1, wdata=10. Next cycle: out_valid=1, out_kind=1, out_pc=0x80000004, out_waddr=1, out_wdata=10, out_seq=0.
- Same-cycle ordering: both lanes valid (pc 0x100, 0x104; lane0 wen=0) plus trap_valid with cause=0x2. Drain order is exactly: kind0 pc 0x100, then kind1 pc 0x104, then kind2 wdata=0x2. out_seq runs 0, 1, 2.
- Backpressure/full (DEPTH=8, COMMITS=2): hold out_ready=0 and present 2 commits per cycle. Accepts at levels 0, 2, 4; in_ready goes 0 at level 6. The next presented group is dropped and overflow=1. Releasing out_ready drains 6 entries in order.
- Simultaneous enq/deq at level 5: one dequeue plus a 2-commit group gives level 6 next cycle. Pointer wrap past slot 7 must preserve order.
- Sequence wrap: dequeue 65537 entries; out_seq reads 0xFFFF then 0x0000. Asserting reset mid-burst gives out_valid=0 and level=0 on the next cycle.
